// File: rtl/ktc16_uart_pkg.sv
// Shared types and constants for the ktc16 memory-mapped UART transmitter.
package ktc16_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_FULL = 1;
  localparam int unsigned ST_OVF  = 2;

endpackage

// File: rtl/ktc16_uart_tx_if.sv
// Store-path snoop bus from the ktc16 core into the UART transmitter.
interface ktc16_uart_tx_if;
  logic        memwrite;
  logic [15:0] addr;
  logic [15:0] wd;

  modport master (output memwrite, output addr, output wd);
  modport slave  (input  memwrite, input  addr, input  wd);
endinterface

// File: rtl/ktc16_uart_tx_sync_fifo.sv
// Circular-buffer FIFO with show-ahead head output; pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the count unchanged
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/ktc16_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the ktc16 store path.
module ktc16_uart_tx
  import ktc16_uart_pkg::*;
#(
  parameter logic [15:0] DATA_ADDR    = 16'h0060,
  parameter logic [15:0] STAT_ADDR    = 16'h0062,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ktc16_uart_tx_if.slave        bus,
  output logic                  tx,
  output logic                  busy,
  output logic                  full,
  output logic                  overflow,
  output logic [15:0]           status
);
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic       push_req, clr_req, accept, pop, empty;
  logic [7:0] dout;
  logic       unused_wd;

  assign unused_wd = ^bus.wd[15:8];

  assign push_req = bus.memwrite && (bus.addr == DATA_ADDR);
  assign clr_req  = bus.memwrite && (bus.addr == STAT_ADDR);
  assign accept   = push_req && (!full || pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (accept),
    .pop   (pop),
    .din   (bus.wd[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // A dropped push sets the flag even if a clear lands on the same edge
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && !accept) begin
      ovf_d = 1'b1;
    end else if (clr_req) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = dout;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx comes straight from a flop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = !empty || (state_q != IDLE);
  assign overflow = ovf_q;

  always_comb begin
    status          = '0;
    status[ST_BUSY] = busy;
    status[ST_FULL] = full;
    status[ST_OVF]  = overflow;
  end
endmodule

// File: tb/tb_ktc16_uart_tx.sv
// Directed bench for ktc16_uart_tx: table-driven single stores plus multi-cycle corner sequences.
module tb_ktc16_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx, busy, full, overflow;
  logic [15:0] status;

  int checks = 0;
  int errors = 0;

  ktc16_uart_tx_if bus();

  ktc16_uart_tx #(
    .DATA_ADDR    (16'h0060),
    .STAT_ADDR    (16'h0062),
    .CLKS_PER_BIT (16),
    .DEPTH        (4)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow),
    .status   (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wd;
    logic        exp_busy;
    logic [9:0]  frame;   // bit 0 = start bit, bit 9 = stop bit
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge; the store is sampled by the following posedge.
  task automatic drive(input logic [15:0] a, input logic [15:0] d);
    bus.memwrite = 1'b1;
    bus.addr     = a;
    bus.wd       = d;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus.memwrite = 1'b0;
    bus.addr     = 16'h0000;
    bus.wd       = 16'h0000;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    drive(v.addr, v.wd);
    bus_idle();
    check($sformatf("v%0d busy_after_store", id), busy, v.exp_busy);
    repeat (8) @(negedge clk);
    check($sformatf("v%0d bit0", id), tx, v.frame[0]);
    for (int k = 1; k < 10; k++) begin
      repeat (16) @(negedge clk);
      check($sformatf("v%0d bit%0d", id, k), tx, v.frame[k]);
    end
    repeat (8) @(negedge clk);
    check($sformatf("v%0d busy_last_cycle", id), busy, v.exp_busy);
    @(negedge clk);
    check($sformatf("v%0d busy_done", id), busy, 1'b0);
    check($sformatf("v%0d tx_idle", id), tx, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  logic [19:0] b2b;
  int          n;

  initial begin
    vecs[0] = '{16'h0060, 16'h0041, 1'b1, {1'b1, 8'h41, 1'b0}};
    vecs[1] = '{16'h0050, 16'h00FF, 1'b0, 10'h3FF};
    vecs[2] = '{16'h0054, 16'h0001, 1'b0, 10'h3FF};
    vecs[3] = '{16'h0061, 16'h0041, 1'b0, 10'h3FF};
    vecs[4] = '{16'h0060, 16'h12C3, 1'b1, {1'b1, 8'hC3, 1'b0}};
    vecs[5] = '{16'h0060, 16'h0000, 1'b1, {1'b1, 8'h00, 1'b0}};
    vecs[6] = '{16'h0060, 16'h00FF, 1'b1, {1'b1, 8'hFF, 1'b0}};

    bus_idle();
    repeat (2) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset status", status, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle tx", tx, 1'b1);
      check("idle status", status, 16'h0000);
    end

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back: second start bit directly follows first stop bit
    b2b = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    drive(16'h0060, 16'h0055);
    drive(16'h0060, 16'h00AA);
    bus_idle();
    check("b2b first start latency", tx, 1'b0);
    repeat (7) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        repeat (8) @(negedge clk);
        check("b2b last stop cycle", tx, 1'b1);
        @(negedge clk);
        check("b2b second start no gap", tx, 1'b0);
        repeat (7) @(negedge clk);
      end else if (k > 0) begin
        repeat (16) @(negedge clk);
      end
      check($sformatf("b2b bit%0d", k), tx, b2b[k]);
    end
    repeat (8) @(negedge clk);
    check("b2b busy end", busy, 1'b1);
    @(negedge clk);
    check("b2b busy drop", busy, 1'b0);
    repeat (4) @(negedge clk);

    // Overflow: byte 1 pops one edge after its push, so only byte 6 drops
    for (int i = 0; i < 5; i++) begin
      drive(16'h0060, 16'h0030 + 16'(i));
    end
    check("ovf status after 5", status, 16'h0003);
    drive(16'h0060, 16'h0035);
    check("ovf status after 6", status, 16'h0007);
    check("ovf full", full, 1'b1);
    check("ovf flag", overflow, 1'b1);
    drive(16'h0062, 16'h0000);
    bus_idle();
    check("ovf cleared status", status, 16'h0003);
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ovf drain cycles", n, 795);
    check("ovf final status", status, 16'h0000);
    repeat (4) @(negedge clk);

    // Reset during data bit 3 of 0x41 (a zero bit)
    drive(16'h0060, 16'h0041);
    bus_idle();
    repeat (72) @(negedge clk);
    check("rst pre tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst async tx", tx, 1'b1);
    check("rst async busy", busy, 1'b0);
    check("rst async status", status, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst released tx", tx, 1'b1);
    run_vec(vecs[0], 10);
    run_vec(vecs[4], 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
